shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle controller that sequences the shared ALU through iterated single-bit shift/rotate steps for SHL/SHR/SAR/ROL/ROR/RCL/RCR with an immediate or CL count. It sits between the microcode engine and the ALU. It latches the operand, count and flags on `start`, then drives the ALU one 1-bit step per cycle, feeding each result and its flags back as the next step's inputs. It signals completion with a one-cycle `done` pulse.

## Interface
- No parameters; widths fixed by the 16-bit datapath.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  `MC_ALUOp_t_BITS`  ALUOp_* code; shift ops only: SHL, SHR, SAR, ROL, ROR, RCL, RCR.
- `is_8_bit`  in  1  byte operation.
- `operand`  in  16  value to shift.
- `count`  in  5  shift count, already masked to 5 bits.
- `flags_in`  in  16  architectural flags at start.
- `result`  out  16  working value; final when `done`.
- `flags_out`  out  16  working flags; final when `done`.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle completion pulse.
- `alu_a`  out  16  working value to ALU `a`.
- `alu_op`  out  `MC_ALUOp_t_BITS`  latched op.
- `alu_is_8_bit`  out  1  latched width.
- `alu_flags_in`  out  16  working flags.
- `alu_shift_count`  out  5  constant 5'd1.
- `alu_multibit_shift`  out  1  constant 0.
- `alu_out`  in  32  ALU result; only [15:0] used.
- `alu_flags_out`  in  16  ALU flags result.
- `alu_busy`  in  1  ALU stall; step not taken while high.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, `start`=1:
  - Latch op, is_8_bit and flags.
  - Working value = operand, with [15:8] forced to 0 when is_8_bit.
  - remaining = count.
  - Next state is RUN if count != 0 and op is a shift op. Otherwise DONE, with value and flags unchanged; a non-shift op behaves as a pass-through.
- RUN, each cycle with `alu_busy`=0:
  - working value <= alu_out[15:0].
  - working flags <= alu_flags_out.
  - remaining <= remaining-1.
  - When remaining==1 the step is the last one: next state is DONE.
- RUN with `alu_busy`=1: hold all registers and remaining; no step.
- DONE: `done`=1 for exactly this cycle, then IDLE.
- `start` in RUN or DONE is ignored, with no queuing. Microcode must wait for `done`.
- ALU drive outputs are combinational from the working registers and are valid in every state. Values outside RUN are don't-care to the ALU consumer.
- Count range is 0..31 and is never re-masked by width. 8-bit rotates of 9..31 iterate the full count.

## Timing
- Reset values: state IDLE, `result`=0, `flags_out`=0, `busy`=0, `done`=0, remaining=0, latched op=0, latched is_8_bit=0.
- Latency, with `start` accepted in cycle 0 and no stalls:
  - count=N>0: RUN in cycles 1..N; `done`=1 in cycle N+1; IDLE in cycle N+2. A new `start` is accepted in cycle N+2.
  - count=0: `done`=1 in cycle 1.
- Each asserted-`alu_busy` cycle in RUN delays `done` by one cycle.
- `busy` rises in cycle 1 and falls in the cycle after `done`.
- `result`/`flags_out` are stable from the `done` cycle until the next accepted `start`.
- Reset mid-operation, any state: return to IDLE next edge with reset values. No `done` pulse for the aborted op.
- `start` and `reset` in the same cycle: reset wins.

## Test plan
- SHL, 8-bit, operand 0x0081, count 1 -> `done` in cycle 2; `result`=0x0002, CF=1.
- SHR, 16-bit, operand 0x8000, count 15 -> `done` in cycle 16; `result`=0x0001, CF=0; `busy` high cycles 1..16.
- ROL, 16-bit, operand 0x1234, count 31 -> `done` in cycle 32; `result`=0x091A, CF=0.
- Any op, count 0, operand 0xBEEF, flags 0x0ACD -> `done` in cycle 1; `result`=0xBEEF, `flags_out`=0x0ACD; `alu_*` never sampled.
- SAR, 16-bit, 0x8000, count 4, `alu_busy` high in cycles 2 and 3 -> `done` in cycle 7; `result`=0xF800.
- Stress case: `reset` in RUN cycle 3 of a count-10 op, then `start` again in cycle 5 while IDLE. Expected: `busy`=0 after reset; no `done` for the aborted op; the new op completes normally.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// Handshake and ALU-drive bundle between microcode, shift sequencer and ALU.
interface shift_sequencer_if;
  localparam int unsigned OP_W      = 5;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned FLAG_W    = 16;
  localparam int unsigned ALU_OUT_W = 32;

  // Microcode request side
  logic                 start;
  logic [OP_W-1:0]      op;
  logic                 is_8_bit;
  logic [DATA_W-1:0]    operand;
  logic [CNT_W-1:0]     count;
  logic [FLAG_W-1:0]    flags_in;
  logic [DATA_W-1:0]    result;
  logic [FLAG_W-1:0]    flags_out;
  logic                 busy;
  logic                 done;

  // Shared ALU side
  logic [DATA_W-1:0]    alu_a;
  logic [OP_W-1:0]      alu_op;
  logic                 alu_is_8_bit;
  logic [FLAG_W-1:0]    alu_flags_in;
  logic [CNT_W-1:0]     alu_shift_count;
  logic                 alu_multibit_shift;
  logic [ALU_OUT_W-1:0] alu_out;
  logic [FLAG_W-1:0]    alu_flags_out;
  logic                 alu_busy;

  // Requester side: microcode engine plus the ALU it shares
  modport master (
    output start, op, is_8_bit, operand, count, flags_in,
    output alu_out, alu_flags_out, alu_busy,
    input  result, flags_out, busy, done,
    input  alu_a, alu_op, alu_is_8_bit, alu_flags_in, alu_shift_count, alu_multibit_shift
  );

  // Sequencer side
  modport slave (
    input  start, op, is_8_bit, operand, count, flags_in,
    input  alu_out, alu_flags_out, alu_busy,
    output result, flags_out, busy, done,
    output alu_a, alu_op, alu_is_8_bit, alu_flags_in, alu_shift_count, alu_multibit_shift
  );
endinterface

// File: rtl/shift_sequencer.sv
// Iterates the shared ALU one 1-bit shift/rotate step per cycle until the
// requested count is exhausted, then pulses done for one cycle.
module shift_sequencer (
  input  logic              clk,
  input  logic              reset,
  shift_sequencer_if.slave  bus
);
  localparam int unsigned OP_W   = 5;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned FLAG_W = 16;

  localparam logic [OP_W-1:0] ALUOP_SHL = OP_W'(9);
  localparam logic [OP_W-1:0] ALUOP_SHR = OP_W'(10);
  localparam logic [OP_W-1:0] ALUOP_SAR = OP_W'(11);
  localparam logic [OP_W-1:0] ALUOP_ROL = OP_W'(12);
  localparam logic [OP_W-1:0] ALUOP_ROR = OP_W'(13);
  localparam logic [OP_W-1:0] ALUOP_RCL = OP_W'(14);
  localparam logic [OP_W-1:0] ALUOP_RCR = OP_W'(15);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_value;
  logic [FLAG_W-1:0]   r_flags;
  logic [CNT_W-1:0]    r_remaining;
  logic [OP_W-1:0]     r_op;
  logic                r_is_8_bit;
  logic                r_busy;
  logic                r_done;

  state_t              w_state_next;
  logic [DATA_W-1:0]   w_value_next;
  logic [FLAG_W-1:0]   w_flags_next;
  logic [CNT_W-1:0]    w_remaining_next;
  logic [OP_W-1:0]     w_op_next;
  logic                w_is_8_bit_next;
  logic                w_is_shift;
  logic                w_unused_alu_hi;

  // Only the shift/rotate family is iterated; anything else passes through
  assign w_is_shift = (bus.op inside {ALUOP_SHL, ALUOP_SHR, ALUOP_SAR,
                                      ALUOP_ROL, ALUOP_ROR, ALUOP_RCL, ALUOP_RCR});

  // Upper half of the ALU result is meaningless for a 16-bit shift
  assign w_unused_alu_hi = ^bus.alu_out[31:16];

  // Next-state and working-register update
  always_comb begin
    w_state_next     = r_state;
    w_value_next     = r_value;
    w_flags_next     = r_flags;
    w_remaining_next = r_remaining;
    w_op_next        = r_op;
    w_is_8_bit_next  = r_is_8_bit;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_op_next        = bus.op;
          w_is_8_bit_next  = bus.is_8_bit;
          w_flags_next     = bus.flags_in;
          w_value_next     = bus.is_8_bit ? {8'h00, bus.operand[7:0]} : bus.operand;
          w_remaining_next = bus.count;
          w_state_next     = ((bus.count != '0) && w_is_shift) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (!bus.alu_busy) begin
          w_value_next     = bus.alu_out[DATA_W-1:0];
          w_flags_next     = bus.alu_flags_out;
          w_remaining_next = r_remaining - CNT_W'(1);
          if (r_remaining == CNT_W'(1)) begin
            w_state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State and working registers; busy/done are registered decodes of next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_value     <= '0;
      r_flags     <= '0;
      r_remaining <= '0;
      r_op        <= '0;
      r_is_8_bit  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_value     <= w_value_next;
      r_flags     <= w_flags_next;
      r_remaining <= w_remaining_next;
      r_op        <= w_op_next;
      r_is_8_bit  <= w_is_8_bit_next;
      r_busy      <= (w_state_next != ST_IDLE);
      r_done      <= (w_state_next == ST_DONE);
    end
  end

  assign bus.result             = r_value;
  assign bus.flags_out          = r_flags;
  assign bus.busy               = r_busy;
  assign bus.done               = r_done;
  assign bus.alu_a              = r_value;
  assign bus.alu_op             = r_op;
  assign bus.alu_is_8_bit       = r_is_8_bit;
  assign bus.alu_flags_in       = r_flags;
  assign bus.alu_shift_count    = CNT_W'(1);
  assign bus.alu_multibit_shift = 1'b0;
endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: a 1-bit-step ALU model closes the loop, and the
// final value/flags are predicted by a whole-count reference computed directly.
module tb_shift_sequencer;
  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SHL = 5'd9;
  localparam logic [4:0] OP_SHR = 5'd10;
  localparam logic [4:0] OP_SAR = 5'd11;
  localparam logic [4:0] OP_ROL = 5'd12;
  localparam logic [4:0] OP_ROR = 5'd13;
  localparam logic [4:0] OP_RCL = 5'd14;
  localparam logic [4:0] OP_RCR = 5'd15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_sequencer_if bus();
  shift_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  function automatic bit is_shift(input logic [4:0] op);
    return (op >= OP_SHL) && (op <= OP_RCR);
  endfunction

  // One 1-bit ALU step; only CF (bit 0) is modelled, other flags pass through
  function automatic logic [31:0] alu_step(input logic [4:0] op, input logic w8,
                                           input logic [15:0] a, input logic [15:0] f);
    int unsigned wd;
    logic [15:0] m, av, r;
    logic msb, lsb, cf, nc;
    wd  = w8 ? 8 : 16;
    m   = w8 ? 16'h00FF : 16'hFFFF;
    av  = a & m;
    msb = av[wd-1];
    lsb = av[0];
    cf  = f[0];
    case (op)
      OP_SHL:  begin r = av << 1;                          nc = msb; end
      OP_SHR:  begin r = av >> 1;                          nc = lsb; end
      OP_SAR:  begin r = (av >> 1) | (16'(msb) << (wd-1)); nc = lsb; end
      OP_ROL:  begin r = (av << 1) | 16'(msb);             nc = msb; end
      OP_ROR:  begin r = (av >> 1) | (16'(lsb) << (wd-1)); nc = lsb; end
      OP_RCL:  begin r = (av << 1) | 16'(cf);              nc = msb; end
      OP_RCR:  begin r = (av >> 1) | (16'(cf) << (wd-1));  nc = lsb; end
      default: begin r = av;                               nc = cf;  end
    endcase
    r = r & m;
    return {f[15:1], nc, r};
  endfunction

  // ALU stand-in; returns garbage while stalled so a stalled step cannot be latched
  logic [31:0] w_step;
  always_comb begin
    w_step            = alu_step(bus.alu_op, bus.alu_is_8_bit, bus.alu_a, bus.alu_flags_in);
    bus.alu_out       = bus.alu_busy ? 32'hFFFF_FFFF : {16'hA5A5, w_step[15:0]};
    bus.alu_flags_out = bus.alu_busy ? 16'hFFFF : w_step[31:16];
  end

  // Whole-count result {flags, value} from closed-form shift/rotate arithmetic
  function automatic logic [31:0] ref_op(input logic [4:0] op, input logic w8,
                                         input logic [15:0] operand, input logic [4:0] count,
                                         input logic [15:0] flags);
    longint unsigned m, m1, v, t, res, x, x2, sv;
    longint s;
    int n, wd, k;
    logic ncf;
    wd = w8 ? 8 : 16;
    m  = w8 ? 64'hFF : 64'hFFFF;
    v  = 64'(operand) & m;
    n  = int'(count);
    if (!is_shift(op) || n == 0) return {flags, 16'(v)};
    x  = (64'(flags[0]) << wd) | v;
    m1 = (m << 1) | 64'd1;
    case (op)
      OP_SHL: begin
        t = v << n; res = t & m; ncf = 1'((t >> wd) & 64'd1);
      end
      OP_SHR: begin
        res = v >> n; ncf = 1'((v >> (n-1)) & 64'd1);
      end
      OP_SAR: begin
        sv = (((v >> (wd-1)) & 64'd1) != 0) ? (v | ~m) : v;
        s = sv;
        res = (s >>> n) & m;
        ncf = 1'((s >>> (n-1)) & 64'd1);
      end
      OP_ROL: begin
        k = n % wd; res = ((v << k) | (v >> (wd-k))) & m; ncf = 1'(res & 64'd1);
      end
      OP_ROR: begin
        k = n % wd; res = ((v >> k) | (v << (wd-k))) & m; ncf = 1'((res >> (wd-1)) & 64'd1);
      end
      OP_RCL: begin
        k = n % (wd+1); x2 = ((x << k) | (x >> (wd+1-k))) & m1;
        res = x2 & m; ncf = 1'((x2 >> wd) & 64'd1);
      end
      default: begin
        k = n % (wd+1); x2 = ((x >> k) | (x << (wd+1-k))) & m1;
        res = x2 & m; ncf = 1'((x2 >> wd) & 64'd1);
      end
    endcase
    return {flags[15:1], ncf, 16'(res)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered #1 after a posedge in IDLE; that cycle is cycle 0 of the request.
  // Returns #1 after the posedge following done (IDLE, ready for a new start).
  task automatic run_op(input logic [4:0] op, input logic w8, input logic [15:0] operand,
                        input logic [4:0] count, input logic [15:0] flags,
                        input logic [63:0] stall, input bit junk);
    logic [31:0] exp;
    int exp_done, rem, done_cyc;
    bit got_done;
    exp = ref_op(op, w8, operand, count, flags);
    exp_done = 1;
    if (is_shift(op) && count != 0) begin
      rem = int'(count);
      while (rem > 0) begin
        if (!stall[exp_done]) rem--;
        exp_done++;
      end
    end
    bus.start = 1'b1; bus.op = op; bus.is_8_bit = w8;
    bus.operand = operand; bus.count = count; bus.flags_in = flags;
    bus.alu_busy = stall[0];
    got_done = 0; done_cyc = 0;
    for (int c = 1; c <= 200 && !got_done; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        check("alu_op_latched", 32'(bus.alu_op), 32'(op));
        check("alu_w8_latched", 32'(bus.alu_is_8_bit), 32'(w8));
        check("alu_consts", {16'(bus.alu_shift_count), 16'(bus.alu_multibit_shift)},
              {16'd1, 16'd0});
      end
      check("busy_active", 32'(bus.busy), 32'd1);
      if (bus.done) begin
        got_done = 1; done_cyc = c;
      end
      bus.alu_busy = (c < 64) ? stall[c] : 1'b0;
      if (junk) begin
        bus.start = 1'($urandom); bus.op = 5'($urandom); bus.is_8_bit = 1'($urandom);
        bus.operand = 16'($urandom); bus.count = 5'($urandom); bus.flags_in = 16'($urandom);
      end else begin
        bus.start = 1'b0;
      end
    end
    check("done_cycle", 32'(done_cyc), 32'(exp_done));
    check("result", 32'(bus.result), {16'd0, exp[15:0]});
    check("flags_out", 32'(bus.flags_out), {16'd0, exp[31:16]});
    @(posedge clk); #1;
    bus.start = 1'b0; bus.alu_busy = 1'b0;
    check("idle_after_done", {16'(bus.busy), 16'(bus.done)}, 32'd0);
    check("result_stable", 32'(bus.result), {16'd0, exp[15:0]});
  endtask

  logic [4:0]  r_op_tbl [8] = '{OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR, OP_RCL, OP_RCR, OP_ADD};
  logic [63:0] stall_mask;

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.is_8_bit = 1'b0; bus.operand = '0;
    bus.count = '0; bus.flags_in = '0; bus.alu_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flags", 32'(bus.flags_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_alu_op", 32'(bus.alu_op), 32'd0);
    check("rst_alu_w8", 32'(bus.alu_is_8_bit), 32'd0);

    // Directed cases
    run_op(OP_SHL, 1'b1, 16'h0081, 5'd1, 16'h0000, 64'd0, 0);
    check("shl8_cf", 32'(bus.flags_out[0]), 32'd1);
    run_op(OP_SHR, 1'b0, 16'h8000, 5'd15, 16'h0001, 64'd0, 0);
    check("shr16_result", 32'(bus.result), 32'h0001);
    run_op(OP_ROL, 1'b0, 16'h1234, 5'd31, 16'h0001, 64'd0, 0);
    check("rol31_result", 32'(bus.result), 32'h091A);
    run_op(OP_SHL, 1'b0, 16'hBEEF, 5'd0, 16'h0ACD, 64'd0, 0);
    check("cnt0_flags", 32'(bus.flags_out), 32'h0ACD);
    run_op(OP_ADD, 1'b0, 16'hBEEF, 5'd5, 16'h0ACD, 64'd0, 0);
    run_op(OP_SAR, 1'b0, 16'h8000, 5'd4, 16'h0000, 64'h0C, 0);
    check("sar_stall_result", 32'(bus.result), 32'hF800);
    run_op(OP_ROL, 1'b1, 16'hFF96, 5'd20, 16'h0000, 64'd0, 0);
    run_op(OP_RCL, 1'b1, 16'h12C3, 5'd9, 16'h0001, 64'd0, 0);
    run_op(OP_RCR, 1'b0, 16'h0001, 5'd31, 16'h0000, 64'd0, 1);

    // Reset and start in the same cycle: reset wins
    reset = 1'b1; bus.start = 1'b1; bus.op = OP_SHL; bus.count = 5'd0; bus.operand = 16'h1111;
    @(posedge clk); #1;
    reset = 1'b0; bus.start = 1'b0;
    check("rst_start_busy", 32'(bus.busy), 32'd0);
    check("rst_start_done", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    check("rst_start_nodone", 32'(bus.done), 32'd0);

    // Reset in RUN cycle 3 of a count-10 op, then a fresh op in cycle 5
    bus.start = 1'b1; bus.op = OP_SHL; bus.is_8_bit = 1'b0;
    bus.operand = 16'h00F0; bus.count = 5'd10; bus.flags_in = 16'h0004;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("abort_run_busy", 32'(bus.busy), 32'd1);
      check("abort_run_done", 32'(bus.done), 32'd0);
      if (c == 3) reset = 1'b1;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_flags", 32'(bus.flags_out), 32'd0);
    @(posedge clk); #1;
    check("abort_nodone", {16'(bus.busy), 16'(bus.done)}, 32'd0);
    run_op(OP_ROR, 1'b0, 16'hA5C3, 5'd7, 16'h0880, 64'd0, 0);

    // Randomized operations with random stalls and ignored mid-operation starts
    for (int i = 0; i < 40; i++) begin
      stall_mask = {32'($urandom), 32'($urandom)} & {32'($urandom), 32'($urandom)};
      run_op(r_op_tbl[$urandom_range(7, 0)], 1'($urandom), 16'($urandom), 5'($urandom),
             16'($urandom), stall_mask, bit'($urandom_range(1, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
